// File: rtl/pattern_seq_pkg.sv
// Shared types for the pattern sequencer: run-state encoding and hold counter width.
package pattern_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  localparam int HOLD_W = 16;

endpackage

// File: rtl/pattern_sequencer_hold_timer.sv
// Hold-window timer: counts cycles within one pattern window and flags the last one.
module hold_timer
  import pattern_seq_pkg::*;
#(
  parameter int HOLD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [HOLD_W-1:0] TC_VAL = HOLD_W'(HOLD - 1);

  logic [HOLD_W-1:0] r_cnt;

  // clr wins over en so a window boundary restarts the count at zero
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/pattern_sequencer.sv
// Steps a cell's inputs through patterns 0..LAST, holds each HOLD cycles, and
// checks the cell's sampled output against the truth table EXP.
module pattern_sequencer
  import pattern_seq_pkg::*;
#(
  parameter int                 N_IN = 5,
  parameter int                 HOLD = 10,
  parameter int                 LAST = 4,
  parameter logic [2**N_IN-1:0] EXP  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              y_in,
  output logic [N_IN-1:0]   vec_out,
  output logic              busy,
  output logic              done,
  output logic [2**N_IN-1:0] resp,
  output logic [N_IN:0]     mismatch_cnt,
  output logic [N_IN-1:0]   first_fail
);

  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(LAST);

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic [N_IN-1:0]   r_idx;
  logic [2**N_IN-1:0] r_resp;
  logic [N_IN:0]     r_mm_cnt;
  logic [N_IN-1:0]   r_first_fail;

  logic w_tc;
  logic w_start_go;
  logic w_window_end;
  logic w_last;
  logic w_mis;
  logic w_hold_clr;
  logic w_hold_en;

  assign w_start_go   = (r_state != APPLY) && start && !abort;
  assign w_window_end = (r_state == APPLY) && w_tc && !abort;
  assign w_last       = (r_idx == LAST_IDX);
  assign w_mis        = (y_in != EXP[r_idx]);
  assign w_hold_clr   = w_start_go || w_window_end || abort;
  assign w_hold_en    = (r_state == APPLY);

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk (clk),
    .rst (rst),
    .clr (w_hold_clr),
    .en  (w_hold_en),
    .tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // abort outranks start; start is only honoured outside APPLY
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) w_next = APPLY;
        APPLY:      if (w_tc && w_last) w_next = DONE;
        default:    w_next = IDLE;
      endcase
    end
  end

  // vec_out is r_idx itself, so it changes only on window boundaries
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_resp       <= '0;
      r_mm_cnt     <= '0;
      r_first_fail <= '0;
    end else if (abort) begin
      r_idx <= '0;
    end else if (w_start_go) begin
      r_idx        <= '0;
      r_resp       <= '0;
      r_mm_cnt     <= '0;
      r_first_fail <= '0;
    end else if (w_window_end) begin
      r_resp[r_idx] <= y_in;
      if (w_mis) begin
        r_mm_cnt <= r_mm_cnt + 1'b1;
        if (r_mm_cnt == '0) begin
          r_first_fail <= r_idx;
        end
      end
      if (!w_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign vec_out      = r_idx;
  assign busy         = (r_state == APPLY);
  assign done         = (r_state == DONE);
  assign resp         = r_resp;
  assign mismatch_cnt = r_mm_cnt;
  assign first_fail   = r_first_fail;

endmodule
